// File: rtl/fifo_stream_reader_pkg.sv
// Shared types for the FIFO read-side stream master.
// Occupancy encoding and default word width.
package SHARED_pkg;

  localparam int FIFO_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order buffer absorbing the FIFO read latency.
// Head is the oldest word; tail holds the second entry.
module fifo_skid_buf
  import SHARED_pkg::*;
#(
  parameter int W = FIFO_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output occ_e         o_occ,
  output logic [W-1:0] o_head,
  output logic         o_overrun
);

  occ_e           r_occ;
  logic [W-1:0]   r_head;
  logic [W-1:0]   r_tail;
  logic           w_pop;

  // a pop on an empty buffer is meaningless, so ignore it
  assign w_pop     = i_pop & (r_occ != OCC_EMPTY);
  assign o_overrun = i_push & ~w_pop & (r_occ == OCC_TWO);
  assign o_occ     = r_occ;
  assign o_head    = r_head;

  // occupancy and entry update for push/pop combinations
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ  <= OCC_EMPTY;
      r_head <= '0;
      r_tail <= '0;
    end else begin
      case (r_occ)
        OCC_EMPTY: begin
          if (i_push) begin
            r_head <= i_din;
            r_occ  <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          unique case ({i_push, w_pop})
            2'b10: begin
              r_tail <= i_din;
              r_occ  <= OCC_TWO;
            end
            2'b01: r_occ <= OCC_EMPTY;
            2'b11: r_head <= i_din;
            2'b00: ;
          endcase
        end
        OCC_TWO: begin
          unique case ({i_push, w_pop})
            2'b10: ;
            2'b01: begin
              r_head <= r_tail;
              r_occ  <= OCC_ONE;
            end
            2'b11: begin
              r_head <= r_tail;
              r_tail <= i_din;
            end
            2'b00: ;
          endcase
        end
        default: r_occ <= OCC_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// FIFO read-side master: issues reads, buffers the
// registered read data and presents a valid/ready stream.
module fifo_stream_reader
  import SHARED_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [FIFO_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  err
);

  occ_e                  w_occ;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_overrun;
  logic [2:0]            w_level;
  logic                  r_inflight;
  logic [CNT_WIDTH-1:0]  r_count;
  logic                  r_err;

  assign m_valid = (w_occ != OCC_EMPTY);
  assign w_pop   = m_valid & m_ready;
  assign w_push  = r_inflight & ~fifo_underflow;

  // occupancy after this cycle's pop plus the word in flight;
  // pop implies occ >= 1, so this never goes negative
  assign w_level = {1'b0, w_occ} + {2'b0, r_inflight}
                 - {2'b0, w_pop};

  assign fifo_rd_en = rst_n & en & ~fifo_empty
                    & (w_level < 3'd2);

  assign rd_count = r_count;
  assign err      = r_err;

  fifo_skid_buf #(
    .W (FIFO_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_push),
    .i_din     (fifo_data_out),
    .i_pop     (w_pop),
    .o_occ     (w_occ),
    .o_head    (m_data),
    .o_overrun (w_overrun)
  );

  // track whether read data arrives next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_inflight <= 1'b0;
    else        r_inflight <= fifo_rd_en & ~fifo_empty;
  end

  // count delivered words, wrapping naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_count <= '0;
    else if (w_pop) r_count <= r_count + 1'b1;
  end

  // sticky error on underflowed capture or buffer overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 1'b0;
    else        r_err <= r_err
                       | (r_inflight & fifo_underflow)
                       | w_overrun;
  end

endmodule
